csa_accumulator: RTL and testbench
==================================

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 Parameter WIDTH, default 4: unsigned input operand width, SHALL be >= 2.
REQ-002 Parameter ACC_WIDTH, default 6: accumulator and result width, SHALL be >= WIDTH+1.
REQ-003 Parameter CNT_WIDTH, default 5: beat counter width, SHALL be >= 1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  operand beat offered.
REQ-007 in_ready  out  1  block accepts beat; transfer = in_valid & in_ready at rising edge.
REQ-008 in_data  in  WIDTH  unsigned operand, zero-extended to ACC_WIDTH.
REQ-009 in_last  in  1  marks final beat of frame; sampled only on transfer.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer accepts result; handshake = out_valid & out_ready.
REQ-012 out_sum  out  ACC_WIDTH  frame sum modulo 2^ACC_WIDTH.
REQ-013 out_ovf  out  1  true frame sum >= 2^ACC_WIDTH.
REQ-014 out_count  out  CNT_WIDTH  beats in frame, saturating at 2^CNT_WIDTH-1.

Function
REQ-015 State machine SHALL have states IDLE, ACCUM, RESOLVE, DONE.
REQ-016 Internal state: sum vector S, carry vector C (both ACC_WIDTH), sticky ovf flag, beat counter; frame value = S + C.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, 0 in RESOLVE and DONE.
REQ-018 On transfer: S <= S ^ C ^ D; C <= (maj(S,C,D) << 1) truncated to ACC_WIDTH; ovf <= ovf | maj(S,C,D)[ACC_WIDTH-1]; counter increments, saturating.
REQ-019 Transfer in IDLE with in_last=0 -> ACCUM; transfer with in_last=1 (IDLE or ACCUM) -> RESOLVE; ACCUM otherwise holds.
REQ-020 RESOLVE SHALL last exactly one cycle: carry-propagate add S + C; out_sum <= low ACC_WIDTH bits; out_ovf <= ovf | CPA carry-out; out_count <= counter; out_valid <= 1; -> DONE.
REQ-021 Latency: transfer with in_last at edge t -> out_valid high after edge t+1.
REQ-022 DONE: out_valid, out_sum, out_ovf, out_count SHALL hold stable until handshake.
REQ-023 On handshake: out_valid <= 0; S, C, ovf, counter cleared; -> IDLE; in_ready high the following cycle.
REQ-024 in_valid while in_ready=0 SHALL be ignored, no state change.
REQ-025 A frame SHALL contain >= 1 beat; no empty-frame mechanism exists.
REQ-026 out_sum, out_ovf, out_count SHALL retain last result after handshake until next RESOLVE.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE; S, C, ovf, counter, out_sum, out_ovf, out_count = 0; out_valid = 0; in_ready = 1 once in IDLE.
REQ-028 Reset mid-frame or in DONE SHALL discard the partial frame or pending result; no output produced for it.

Structure
REQ-029 Shared package csa_acc_pkg SHALL hold the state encoding and default parameter constants.
REQ-030 The per-bit 3:2 compressor and CPA cell SHALL use sub-module full_adder (sum = a^b^cin, cout = majority), instantiated via generate over ACC_WIDTH.
REQ-031 CPA SHALL be a ripple chain of full_adder with cin = 0.

Verification (WIDTH=4, ACC_WIDTH=6, CNT_WIDTH=5)
REQ-032 Beats 3,5,7(last), out_ready=1 -> out_sum=15, out_ovf=0, out_count=3, out_valid high 2 edges after last beat.
REQ-033 16 beats of 15 -> out_sum=48, out_ovf=1, out_count=16.
REQ-034 Single beat 9 with in_last -> out_sum=9, out_ovf=0, out_count=1.
REQ-035 out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no beats absorbed; next frame 2,2(last) -> out_sum=4.
REQ-036 rst_n low after beats 1,1 -> all outputs 0; after release, frame 1,1(last) -> out_sum=2, out_count=2.
REQ-037 40 beats of 1 -> out_count=31 (saturated), out_sum=40 mod 64=40, out_ovf=0.

Source files
------------

// File: rtl/csa_acc_pkg.sv
// Shared definitions for the carry-save accumulator.
// Holds the state encoding and the default parameter constants used by
// csa_accumulator.
package csa_acc_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ACC_WIDTH = 6;
  localparam int DEF_CNT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder.
// It serves as the per-bit 3:2 compressor cell and as the ripple-carry adder cell.
// Ports: a, b, cin  - the three input bits
//        sum        - a ^ b ^ cin
//        cout       - majority(a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_accumulator.sv
// Carry-save frame accumulator.
// Beats of a frame are folded into a redundant (S, C) pair with one 3:2
// compressor level per beat, so no carry propagates while beats arrive.
// After the last beat, one RESOLVE cycle runs a ripple-carry add of S + C
// and registers the result. The result is held in DONE until the consumer
// takes it.
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   in_valid/in_ready            - operand beat handshake
//   in_data, in_last             - operand beat and end-of-frame marker
//   out_valid/out_ready          - result handshake
//   out_sum, out_ovf, out_count  - frame sum mod 2^ACC_WIDTH, overflow,
//                                  saturating beat count
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic [CNT_WIDTH-1:0] out_count
);

  state_t                 state_r;
  state_t                 state_s;
  logic [ACC_WIDTH-1:0]   s_r;
  logic [ACC_WIDTH-1:0]   c_r;
  logic                   ovf_r;
  logic [CNT_WIDTH-1:0]   cnt_r;

  logic                   xfer_s;
  logic                   hs_s;
  logic [ACC_WIDTH-1:0]   data_ext_s;
  logic [ACC_WIDTH-1:0]   comp_sum_s;
  logic [ACC_WIDTH-1:0]   comp_maj_s;
  logic [ACC_WIDTH-1:0]   comp_carry_s;
  logic [ACC_WIDTH-1:0]   cpa_sum_s;
  logic [ACC_WIDTH:0]     cpa_carry_s;

  // Saturating increment for the beat counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_WIDTH'(1);
    end
  endfunction

  assign xfer_s     = in_valid & in_ready;
  assign hs_s       = out_valid & out_ready;
  assign data_ext_s = {{(ACC_WIDTH-WIDTH){1'b0}}, in_data};

  // The majority bit out of the MSB column has no place in C. It is
  // recorded in the sticky overflow flag instead.
  assign comp_carry_s   = {comp_maj_s[ACC_WIDTH-2:0], 1'b0};
  assign cpa_carry_s[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < ACC_WIDTH; gi++) begin : g_bit
      full_adder u_comp (
        .a   (s_r[gi]),
        .b   (c_r[gi]),
        .cin (data_ext_s[gi]),
        .sum (comp_sum_s[gi]),
        .cout(comp_maj_s[gi])
      );
      full_adder u_cpa (
        .a   (s_r[gi]),
        .b   (c_r[gi]),
        .cin (cpa_carry_s[gi]),
        .sum (cpa_sum_s[gi]),
        .cout(cpa_carry_s[gi+1])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          state_s = in_last ? ST_RESOLVE : ST_ACCUM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (xfer_s && in_last) begin
          state_s = ST_RESOLVE;
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_RESOLVE: begin
        state_s = ST_DONE;
      end
      ST_DONE: begin
        if (hs_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // in_ready is registered from the next state, so it always matches state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= (state_s == ST_IDLE) || (state_s == ST_ACCUM);
    end
  end

  // Carry-save accumulation state. It is cleared when the result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r   <= {ACC_WIDTH{1'b0}};
      c_r   <= {ACC_WIDTH{1'b0}};
      ovf_r <= 1'b0;
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (xfer_s) begin
      s_r   <= comp_sum_s;
      c_r   <= comp_carry_s;
      ovf_r <= ovf_r | comp_maj_s[ACC_WIDTH-1];
      cnt_r <= sat_inc(cnt_r);
    end else if ((state_r == ST_DONE) && hs_s) begin
      s_r   <= {ACC_WIDTH{1'b0}};
      c_r   <= {ACC_WIDTH{1'b0}};
      ovf_r <= 1'b0;
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      s_r   <= s_r;
      c_r   <= c_r;
      ovf_r <= ovf_r;
      cnt_r <= cnt_r;
    end
  end

  // Result registers. They are loaded in RESOLVE and keep their value after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= {ACC_WIDTH{1'b0}};
      out_ovf   <= 1'b0;
      out_count <= {CNT_WIDTH{1'b0}};
    end else if (state_r == ST_RESOLVE) begin
      out_valid <= 1'b1;
      out_sum   <= cpa_sum_s;
      out_ovf   <= ovf_r | cpa_carry_s[ACC_WIDTH];
      out_count <= cnt_r;
    end else if ((state_r == ST_DONE) && hs_s) begin
      out_valid <= 1'b0;
      out_sum   <= out_sum;
      out_ovf   <= out_ovf;
      out_count <= out_count;
    end else begin
      out_valid <= out_valid;
      out_sum   <= out_sum;
      out_ovf   <= out_ovf;
      out_count <= out_count;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator (WIDTH=4, ACC_WIDTH=6, CNT_WIDTH=5).
// Stimulus pushes hand-computed frame results into a queue. A monitor pops
// an entry and compares it on every result handshake.
module tb_csa_accumulator;

  typedef struct packed {
    logic [5:0] sum;
    logic       ovf;
    logic [4:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_sum;
  logic       out_ovf;
  logic [4:0] out_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  csa_accumulator #(.WIDTH(4), .ACC_WIDTH(6), .CNT_WIDTH(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_res(input int s, input int o, input int c);
    exp_t e;
    e.sum = 6'(s);
    e.ovf = 1'(o);
    e.cnt = 5'(c);
    exp_q.push_back(e);
  endtask

  // Monitor: compare each result on the cycle in which it is consumed.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result sum=%0d required=none", out_sum);
      end else begin
        e = exp_q.pop_front();
        chk("res_sum", int'(out_sum), int'(e.sum));
        chk("res_ovf", int'(out_ovf), int'(e.ovf));
        chk("res_count", int'(out_count), int'(e.cnt));
      end
    end
  end

  // Offer one beat (called just after a rising edge). Returns #1 after the transfer edge.
  task automatic beat(input int d, input logic last);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'(d);
    in_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      chk("beat_timeout", 0, 1);
    end
  endtask

  // Wait, with a bound, until every expected result has been consumed.
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_ovf", int'(out_ovf), 0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3+5+7 = 15, result appears one edge after the last-beat edge
    expect_res(15, 0, 3);
    beat(3, 1'b0);
    beat(5, 1'b0);
    beat(7, 1'b1);
    chk("lat_not_yet", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid", int'(out_valid), 1);
    drain();

    // 16 x 15 = 240 -> 240 mod 64 = 48, overflow
    expect_res(48, 1, 16);
    for (int i = 0; i < 15; i++) beat(15, 1'b0);
    beat(15, 1'b1);
    drain();

    // Single-beat frame, then result retained after the handshake
    expect_res(9, 0, 1);
    beat(9, 1'b1);
    drain();
    chk("retain_valid", int'(out_valid), 0);
    chk("retain_sum", int'(out_sum), 9);
    chk("retain_count", int'(out_count), 1);

    // Back-pressure in DONE with in_valid asserted
    out_ready = 1'b0;
    expect_res(8, 0, 2);
    beat(4, 1'b0);
    beat(4, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 4'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_sum", int'(out_sum), 8);
      chk("hold_count", int'(out_count), 2);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    drain();
    expect_res(4, 0, 2);
    beat(2, 1'b0);
    beat(2, 1'b1);
    drain();

    // Reset mid-frame discards the partial frame
    beat(1, 1'b0);
    beat(1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_sum", int'(out_sum), 0);
    chk("mid_rst_count", int'(out_count), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_res(2, 0, 2);
    beat(1, 1'b0);
    beat(1, 1'b1);
    drain();

    // Reset in DONE drops the pending result
    out_ready = 1'b0;
    beat(5, 1'b1);
    @(posedge clk);
    #1;
    chk("done_valid", int'(out_valid), 1);
    chk("done_sum", int'(out_sum), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("done_rst_valid", int'(out_valid), 0);
    chk("done_rst_sum", int'(out_sum), 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // 40 beats of 1 -> counter saturates at 31, sum 40
    expect_res(40, 0, 31);
    for (int i = 0; i < 39; i++) beat(1, 1'b0);
    beat(1, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("final_valid", int'(out_valid), 0);
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
